fp_add_pipe: RTL and testbench
==============================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port operand_1  input  W  IEEE-style {sign, exp, mantissa}.
REQ-008 SHALL have port operand_2  input  W  same format.
REQ-009 SHALL have port op_sub  input  1  1 = operand_1 - operand_2, 0 = add.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port sum  output  W  rounded result.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/compare/swap/align, S2 signed mantissa add/sub, S3 normalise/round/pack.
REQ-015 SHALL accept a transfer when in_valid && in_ready; result appears with out_valid exactly 3 cycles later absent stall.
REQ-016 SHALL assert stall = out_valid && !out_ready; in_ready = !stall (combinational); on stall every stage holds.
REQ-017 SHALL sustain one result per cycle with out_ready high; results in acceptance order, none dropped or duplicated.
REQ-018 SHALL hold sum and flags stable while out_valid && !out_ready.
REQ-019 SHALL use effective sign of operand_2 = sign2 XOR op_sub; effective subtract when signs differ.
REQ-020 SHALL align smaller-magnitude operand right by exponent difference, keeping guard, round and sticky bits; difference >= MAN_W+3 leaves only sticky.
REQ-021 SHALL take result sign from larger-magnitude operand; exact-zero cancellation yields +0, except (-0)+(-0) yields -0.
REQ-022 SHALL normalise by leading-one detection (left shift up to MAN_W+1, or right shift 1 on carry-out), adjusting exponent.
REQ-023 SHALL round to nearest, ties to even; inexact = any of guard/round/sticky set before rounding.
REQ-024 SHALL renormalise if rounding carries out of mantissa, incrementing exponent.
REQ-025 SHALL treat exponent-field-0 inputs (zero/subnormal) as signed zero.
REQ-026 SHALL flush results below minimum normal to signed zero with underflow=1 and inexact=1 (exact zero: no flags).
REQ-027 SHALL on final exponent >= all-ones output signed infinity with overflow=1, inexact=1.
REQ-028 SHALL output infinity of operand sign for inf +/- finite, and for same-effective-sign inf+inf; flags 0.
REQ-029 SHALL output canonical NaN (sign 0, exp all-ones, mantissa MSB 1, rest 0) for any NaN input or effective inf-inf.
REQ-030 SHALL set invalid=1 for effective inf-inf or signalling NaN input (mantissa MSB 0, nonzero); quiet NaN input gives flags 0.
REQ-031 SHALL propagate special-case decisions alongside data through all stages with same latency.

Reset
REQ-032 SHALL on reset_n low, immediately clear all stage valid bits, out_valid=0, sum=0, flags=0.
REQ-033 SHALL discard in-flight operations on reset mid-operation; no result emerges for them after release.
REQ-034 SHALL drive in_ready=1 during and after reset.

Verification (EXP_W=8, MAN_W=23)
REQ-035 SHALL check 0x3F800000 + 0x40000000 -> sum 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
REQ-036 SHALL check 0x3F800000 op_sub 0x3F800000 -> 0x00000000, flags 0; 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1 (tie to even).
REQ-037 SHALL check 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
REQ-038 SHALL check 0x7F800000 op_sub 0x7F800000 -> 0x7FC00000, invalid=1; 0x7FC00000 + 0x3F800000 -> 0x7FC00000, flags 0.
REQ-039 SHALL check 8 back-to-back operations with out_ready low cycles 4-6 -> in_ready low same cycles, all 8 results correct, in order, held stable while stalled.
REQ-040 SHALL check reset_n pulsed low with 3 operations in flight -> out_valid 0 immediately, no stale result after release, next operation correct.

Source files
------------

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (round to nearest even,
// subnormals flushed to zero) with valid/ready handshake and global stall.
module fp_add_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] operand_1,
   input  logic [EXP_W+MAN_W:0] operand_2,
   input  logic                 op_sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] sum,
   output logic [3:0]           flags
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned SW   = MAN_W + 4;
   localparam int unsigned AW   = MAN_W + 5;
   localparam int unsigned XW   = EXP_W + 2;
   localparam int unsigned RW   = MAN_W + 2;
   localparam int unsigned LZ_W = $clog2(SW);

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // operand field decode; op_sub folds into operand_2's sign
   logic             sgn_1, sgn_2;
   logic [EXP_W-1:0] exp_1, exp_2;
   logic [MAN_W-1:0] man_1, man_2;
   logic             zero_1, zero_2, inf_1, inf_2, nan_1, nan_2, snan_1, snan_2;

   assign sgn_1  = operand_1[W-1];
   assign exp_1  = operand_1[MAN_W +: EXP_W];
   assign man_1  = operand_1[MAN_W-1:0];
   assign sgn_2  = operand_2[W-1] ^ op_sub;
   assign exp_2  = operand_2[MAN_W +: EXP_W];
   assign man_2  = operand_2[MAN_W-1:0];
   assign zero_1 = (exp_1 == '0);
   assign zero_2 = (exp_2 == '0);
   assign inf_1  = (exp_1 == '1) && (man_1 == '0);
   assign inf_2  = (exp_2 == '1) && (man_2 == '0);
   assign nan_1  = (exp_1 == '1) && (man_1 != '0);
   assign nan_2  = (exp_2 == '1) && (man_2 != '0);
   assign snan_1 = nan_1 && !man_1[MAN_W-1];
   assign snan_2 = nan_2 && !man_2[MAN_W-1];

   // S1: compare magnitudes, swap, align smaller with guard/round/sticky
   logic                   a_swap, a_sub, a_sgn_l, a_sgn_s, a_spec;
   logic [EXP_W+MAN_W-1:0] a_mag_1, a_mag_2;
   logic [EXP_W-1:0]       a_exp_l, a_dist;
   logic [MAN_W:0]         a_sig_1, a_sig_2, a_sig_l, a_sig_s;
   logic [SW-1:0]          a_man_l, a_man_s, a_ext_s, a_mask;
   logic [W-1:0]           a_spec_res;
   logic [3:0]             a_spec_flg;

   always_comb begin
      a_mag_1 = zero_1 ? '0 : {exp_1, man_1};
      a_mag_2 = zero_2 ? '0 : {exp_2, man_2};
      a_sig_1 = zero_1 ? '0 : {1'b1, man_1};
      a_sig_2 = zero_2 ? '0 : {1'b1, man_2};
      a_swap  = a_mag_2 > a_mag_1;
      a_sub   = sgn_1 ^ sgn_2;
      a_sgn_l = a_swap ? sgn_2 : sgn_1;
      a_sgn_s = a_swap ? sgn_1 : sgn_2;
      a_exp_l = a_swap ? exp_2 : exp_1;
      a_dist  = a_swap ? (exp_2 - exp_1) : (exp_1 - exp_2);
      a_sig_l = a_swap ? a_sig_2 : a_sig_1;
      a_sig_s = a_swap ? a_sig_1 : a_sig_2;
      a_man_l = {a_sig_l, 3'b000};
      a_ext_s = {a_sig_s, 3'b000};
      a_mask  = ~({SW{1'b1}} << a_dist);
      if (a_dist >= EXP_W'(MAN_W + 3)) begin
         a_man_s = {{(SW-1){1'b0}}, |a_sig_s};
      end else begin
         a_man_s    = a_ext_s >> a_dist;
         a_man_s[0] = a_man_s[0] | (|(a_ext_s & a_mask));
      end

      a_spec     = 1'b0;
      a_spec_res = '0;
      a_spec_flg = '0;
      if (nan_1 || nan_2) begin
         a_spec     = 1'b1;
         a_spec_res = QNAN;
         a_spec_flg = {snan_1 | snan_2, 3'b000};
      end else if (inf_1 && inf_2) begin
         a_spec = 1'b1;
         if (a_sub) begin
            a_spec_res = QNAN;
            a_spec_flg = 4'b1000;
         end else begin
            a_spec_res = {sgn_1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
      end else if (inf_1) begin
         a_spec     = 1'b1;
         a_spec_res = {sgn_1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (inf_2) begin
         a_spec     = 1'b1;
         a_spec_res = {sgn_2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   logic             s1_valid, s1_sub, s1_sgn_l, s1_sgn_s, s1_spec;
   logic [EXP_W-1:0] s1_exp;
   logic [SW-1:0]    s1_man_l, s1_man_s;
   logic [W-1:0]     s1_spec_res;
   logic [3:0]       s1_spec_flg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid    <= 1'b0;
         s1_sub      <= 1'b0;
         s1_sgn_l    <= 1'b0;
         s1_sgn_s    <= 1'b0;
         s1_spec     <= 1'b0;
         s1_exp      <= '0;
         s1_man_l    <= '0;
         s1_man_s    <= '0;
         s1_spec_res <= '0;
         s1_spec_flg <= '0;
      end else if (!stall) begin
         s1_valid    <= in_valid;
         s1_sub      <= a_sub;
         s1_sgn_l    <= a_sgn_l;
         s1_sgn_s    <= a_sgn_s;
         s1_spec     <= a_spec;
         s1_exp      <= a_exp_l;
         s1_man_l    <= a_man_l;
         s1_man_s    <= a_man_s;
         s1_spec_res <= a_spec_res;
         s1_spec_flg <= a_spec_flg;
      end
   end

   // S2: magnitude add/subtract; larger operand first so the difference is never negative
   logic [AW-1:0] b_man;
   always_comb begin
      b_man = s1_sub ? ({1'b0, s1_man_l} - {1'b0, s1_man_s})
                     : ({1'b0, s1_man_l} + {1'b0, s1_man_s});
   end

   logic             s2_valid, s2_sgn, s2_zsgn, s2_spec;
   logic [EXP_W-1:0] s2_exp;
   logic [AW-1:0]    s2_man;
   logic [W-1:0]     s2_spec_res;
   logic [3:0]       s2_spec_flg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid    <= 1'b0;
         s2_sgn      <= 1'b0;
         s2_zsgn     <= 1'b0;
         s2_spec     <= 1'b0;
         s2_exp      <= '0;
         s2_man      <= '0;
         s2_spec_res <= '0;
         s2_spec_flg <= '0;
      end else if (!stall) begin
         s2_valid    <= s1_valid;
         s2_sgn      <= s1_sgn_l;
         s2_zsgn     <= s1_sgn_l & s1_sgn_s;
         s2_spec     <= s1_spec;
         s2_exp      <= s1_exp;
         s2_man      <= b_man;
         s2_spec_res <= s1_spec_res;
         s2_spec_flg <= s1_spec_flg;
      end
   end

   // S3: normalise, round to nearest even, detect range limits, pack
   logic [LZ_W-1:0]  c_lead, c_shamt;
   logic [SW-1:0]    c_norm;
   logic [XW-1:0]    c_exp;
   logic [MAN_W:0]   c_mant;
   logic [RW-1:0]    c_rnd;
   logic [MAN_W-1:0] c_frac;
   logic             c_g, c_rs, c_inexact, c_ovf, c_unf;
   logic [W-1:0]     c_res;
   logic [3:0]       c_flg;

   always_comb begin
      c_lead = '0;
      for (int i = 0; i < int'(SW); i++) begin
         if (s2_man[i]) c_lead = LZ_W'(i);
      end
      c_shamt = '0;
      c_exp   = XW'(s2_exp);
      if (s2_man[AW-1]) begin
         c_norm = s2_man[AW-1:1] | SW'(s2_man[0]);
         c_exp  = c_exp + XW'(1);
      end else begin
         c_shamt = LZ_W'(SW - 1) - c_lead;
         c_norm  = s2_man[SW-1:0] << c_shamt;
         c_exp   = c_exp - XW'(c_shamt);
      end
      c_mant    = c_norm[SW-1:3];
      c_g       = c_norm[2];
      c_rs      = |c_norm[1:0];
      c_inexact = c_g | c_rs;
      c_rnd     = {1'b0, c_mant} + RW'(c_g & (c_rs | c_mant[0]));
      c_frac    = c_rnd[MAN_W-1:0];
      if (c_rnd[MAN_W+1]) begin
         c_exp  = c_exp + XW'(1);
         c_frac = c_rnd[MAN_W:1];
      end
      c_ovf = !c_exp[XW-1] && (c_exp >= XW'({EXP_W{1'b1}}));
      c_unf = c_exp[XW-1] || (c_exp == '0);

      c_res = {s2_sgn, c_exp[EXP_W-1:0], c_frac};
      c_flg = {3'b000, c_inexact};
      if (s2_spec) begin
         c_res = s2_spec_res;
         c_flg = s2_spec_flg;
      end else if (s2_man == '0) begin
         c_res = {s2_zsgn, {(W-1){1'b0}}};
         c_flg = 4'b0000;
      end else if (c_ovf) begin
         c_res = {s2_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         c_flg = 4'b0101;
      end else if (c_unf) begin
         c_res = {s2_sgn, {(W-1){1'b0}}};
         c_flg = 4'b0011;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         flags     <= '0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            sum   <= c_res;
            flags <= c_flg;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: table of hand-computed single-precision vectors,
// plus back-to-back stall and mid-flight reset sequences.
module tb_fp_add_pipe;
   localparam int NV = 18;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] s;
      logic [3:0]  f;
   } vec_t;

   logic        clk, reset_n, in_valid, in_ready, op_sub, out_valid, out_ready;
   logic [31:0] operand_1, operand_2, sum;
   logic [3:0]  flags;
   vec_t        tv [NV];
   int          checks = 0;
   int          errors = 0;

   fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // present one vector, measure accept-to-result latency, compare result
   task automatic run_vec(input int i);
      int lat;
      operand_1 = tv[i].a;
      operand_2 = tv[i].b;
      op_sub    = tv[i].sub;
      in_valid  = 1'b1;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d sum", i), sum, tv[i].s);
      check($sformatf("v%0d flags", i), 32'(flags), 32'(tv[i].f));
   endtask

   initial begin
      int idx_in;
      int idx_out;
      int nvalid;

      tv[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0};
      tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
      tv[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
      tv[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
      tv[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
      tv[5]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
      tv[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
      tv[7]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0};
      tv[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};
      tv[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
      tv[10] = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
      tv[11] = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};
      tv[12] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
      tv[13] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'h3};
      tv[14] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0};
      tv[15] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'h0};
      tv[16] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1};
      tv[17] = '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'h1};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_sub    = 1'b0;
      operand_1 = '0;
      operand_2 = '0;
      #3;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset sum", sum, 32'd0);
      check("reset flags", 32'(flags), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) run_vec(i);

      @(posedge clk); #1;
      check("drain out_valid", 32'(out_valid), 32'd0);

      // eight back-to-back operations, consumer stalls in cycles 4..6
      idx_in  = 0;
      idx_out = 0;
      for (int c = 1; c <= 40 && idx_out < 8; c++) begin
         out_ready = !(c >= 4 && c <= 6);
         in_valid  = (idx_in < 8);
         operand_1 = tv[idx_in % 8].a;
         operand_2 = tv[idx_in % 8].b;
         op_sub    = tv[idx_in % 8].sub;
         #1;
         check($sformatf("b2b in_ready c%0d", c), 32'(in_ready), 32'(!(c >= 4 && c <= 6)));
         if (out_valid) begin
            check($sformatf("b2b sum r%0d c%0d", idx_out, c), sum, tv[idx_out].s);
            check($sformatf("b2b flags r%0d c%0d", idx_out, c), 32'(flags), 32'(tv[idx_out].f));
            if (out_ready) idx_out++;
         end
         if (in_valid && in_ready) idx_in++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("b2b result count", 32'(idx_out), 32'd8);
      nvalid = 0;
      repeat (3) begin
         if (out_valid) nvalid++;
         @(posedge clk); #1;
      end
      check("b2b no extra results", 32'(nvalid), 32'd0);

      // three operations in flight, then asynchronous reset
      out_ready = 1'b0;
      idx_in    = 0;
      for (int c = 0; c < 10 && idx_in < 3; c++) begin
         in_valid  = 1'b1;
         operand_1 = tv[8 + idx_in].a;
         operand_2 = tv[8 + idx_in].b;
         op_sub    = tv[8 + idx_in].sub;
         #1;
         if (in_ready) idx_in++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("flight accepted", 32'(idx_in), 32'd3);
      check("flight out_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst sum", sum, 32'd0);
      check("midrst flags", 32'(flags), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("midrst held in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      nvalid    = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) nvalid++;
      end
      check("post-reset stale results", 32'(nvalid), 32'd0);
      run_vec(7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
